// File: rtl/wt_store_wbuf.sv
// Write-through store buffer.
//
// Stores from the core are queued in a small FIFO and issued to memory one
// word at a time. A store to the same word as the newest entry is merged into
// that entry, unless that entry is the head and is currently being requested.
// Memory writes are acknowledged in order. The block tracks the number of
// granted-but-unacknowledged writes and checks each acknowledge TID.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   st_valid_i / st_ready_o   upstream store handshake
//   st_addr_i/data_i/be_i     store byte address, 32-bit data, byte enables
//   mem_req_o / mem_gnt_i     downstream write request handshake
//   mem_addr/data/be/tid_o    head entry (word-aligned address) and issue TID
//   mem_ack_i, mem_ack_tid_i  in-order write acknowledge
//   ld_addr_i / ld_hit_o      load hazard probe against all valid entries
//   empty_o                   no buffered stores and nothing outstanding
//   err_o                     sticky acknowledge protocol error
module wt_store_wbuf #(
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 7,
  parameter int TID_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [31:0]       st_data_i,
  input  logic [3:0]        st_be_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic [3:0]        mem_be_o,
  output logic [TID_W-1:0]  mem_tid_o,
  input  logic              mem_ack_i,
  input  logic [TID_W-1:0]  mem_ack_tid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_hit_o,
  output logic              empty_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int WA_W  = ADDR_W - 2;

  // Entry storage (not reset; validity comes from head/count)
  logic [WA_W-1:0]  ent_addr_q [DEPTH];
  logic [WA_W-1:0]  ent_addr_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [3:0]       ent_be_q   [DEPTH];
  logic [3:0]       ent_be_d   [DEPTH];

  // Control state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [TID_W-1:0] issue_tid_q, issue_tid_d;
  logic [TID_W-1:0] exp_tid_q, exp_tid_d;
  logic             err_q, err_d;

  logic [PTR_W-1:0] tail_ent;
  logic             mem_req;
  logic             coalesce;
  logic             st_ready;
  logic             merge;
  logic             push;
  logic             grant;
  logic             ld_hit;
  logic [PTR_W-1:0] ld_rel;

  // Byte-offset bits play no part in word matching.
  logic unused_addr_lo;
  assign unused_addr_lo = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  // Handshake decode: everything here depends on registered state and the
  // store inputs only, so st_ready_o never depends on mem_gnt_i.
  always_comb begin
    tail_ent = tail_q - PTR_W'(1);
    mem_req  = (count_q != '0) && (out_q < OUT_W'(MAX_OUT));
    // The head entry must stay frozen while it is being requested.
    coalesce = (count_q != '0)
             && (st_addr_i[ADDR_W-1:2] == ent_addr_q[tail_ent])
             && !((tail_ent == head_q) && mem_req);
    st_ready = (count_q < CNT_W'(DEPTH)) || coalesce;
    merge    = st_valid_i && st_ready && coalesce;
    push     = st_valid_i && st_ready && !coalesce;
    grant    = mem_req && mem_gnt_i;
  end

  always_comb begin
    ent_addr_d  = ent_addr_q;
    ent_data_d  = ent_data_q;
    ent_be_d    = ent_be_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_d       = out_q;
    issue_tid_d = issue_tid_q;
    exp_tid_d   = exp_tid_q;
    err_d       = err_q;

    if (merge) begin
      for (int k = 0; k < 4; k++) begin
        if (st_be_i[k]) begin
          ent_data_d[tail_ent][8*k +: 8] = st_data_i[8*k +: 8];
        end
      end
      ent_be_d[tail_ent] = ent_be_q[tail_ent] | st_be_i;
    end

    if (push) begin
      ent_addr_d[tail_q] = st_addr_i[ADDR_W-1:2];
      ent_data_d[tail_q] = st_data_i;
      ent_be_d[tail_q]   = st_be_i;
      tail_d             = tail_q + PTR_W'(1);
    end

    if (grant) begin
      head_d      = head_q + PTR_W'(1);
      issue_tid_d = issue_tid_q + TID_W'(1);
    end

    if (push && !grant) begin
      count_d = count_q + CNT_W'(1);
    end else if (grant && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // Outstanding never overflows: a grant needs out_q < MAX_OUT.
    if (grant && !mem_ack_i) begin
      out_d = out_q + OUT_W'(1);
    end else if (!grant && mem_ack_i && (out_q != '0)) begin
      out_d = out_q - OUT_W'(1);
    end

    if (mem_ack_i) begin
      exp_tid_d = exp_tid_q + TID_W'(1);
      if ((out_q == '0) || (mem_ack_tid_i != exp_tid_q)) begin
        err_d = 1'b1;
      end
    end
  end

  // Load probe: entry i is valid when its distance from head is below count.
  always_comb begin
    ld_hit = 1'b0;
    ld_rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_rel = PTR_W'(i) - head_q;
      if ((CNT_W'(ld_rel) < count_q)
          && (ent_addr_q[i] == ld_addr_i[ADDR_W-1:2])) begin
        ld_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_q       <= '0;
      issue_tid_q <= '0;
      exp_tid_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_q       <= out_d;
      issue_tid_q <= issue_tid_d;
      exp_tid_q   <= exp_tid_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
    ent_be_q   <= ent_be_d;
  end

  assign st_ready_o = st_ready;
  assign mem_req_o  = mem_req;
  assign mem_addr_o = {ent_addr_q[head_q], 2'b00};
  assign mem_data_o = ent_data_q[head_q];
  assign mem_be_o   = ent_be_q[head_q];
  assign mem_tid_o  = issue_tid_q;
  assign ld_hit_o   = ld_hit;
  assign empty_o    = (count_q == '0) && (out_q == '0);
  assign err_o      = err_q;

endmodule

// File: tb/tb_wt_store_wbuf.sv
// Testbench for wt_store_wbuf (default parameters: DEPTH=2, MAX_OUT=7, TID_W=2).
`timescale 1ns/1ps
module tb_wt_store_wbuf;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  st_be_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_be_o;
  logic [1:0]  mem_tid_o;
  logic        mem_ack_i;
  logic [1:0]  mem_ack_tid_i;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic        empty_o;
  logic        err_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  tid;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t got;
  int   vec = 0;
  int   miscomp = 0;

  wt_store_wbuf dut (
    .clk_i(clk), .rst_i(rst_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i),
    .st_data_i(st_data_i), .st_be_i(st_be_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_tid_o(mem_tid_o),
    .mem_ack_i(mem_ack_i), .mem_ack_tid_i(mem_ack_tid_i),
    .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o),
    .empty_o(empty_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; st_be_i = '0;
    mem_gnt_i = 1'b0; mem_ack_i = 1'b0; mem_ack_tid_i = '0; ld_addr_i = '0;
    step(); step();
    rst_i = 1'b0;
    @(negedge clk);
    vec++; if (st_ready_o !== 1'b1) begin miscomp++; $display("FAIL reset_ready: got %b expected 1", st_ready_o); end
    vec++; if (mem_req_o !== 1'b0) begin miscomp++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
    vec++; if (empty_o !== 1'b1) begin miscomp++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    vec++; if (err_o !== 1'b0) begin miscomp++; $display("FAIL reset_err: got %b expected 0", err_o); end
    vec++; if (ld_hit_o !== 1'b0) begin miscomp++; $display("FAIL reset_ldhit: got %b expected 0", ld_hit_o); end
    step();
  endtask

  task automatic test_single();
    st_valid_i = 1'b1; st_addr_i = 32'h8000_0004; st_data_i = 32'hDEAD_BEEF; st_be_i = 4'hF;
    sb.push_back('{addr: 32'h8000_0004, data: 32'hDEAD_BEEF, be: 4'hF, tid: 2'd0});
    @(negedge clk);
    vec++; if (st_ready_o !== 1'b1) begin miscomp++; $display("FAIL single_ready: got %b expected 1", st_ready_o); end
    vec++; if (mem_req_o !== 1'b0) begin miscomp++; $display("FAIL single_req_early: got %b expected 0", mem_req_o); end
    step();
    st_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    vec++; if (mem_req_o !== 1'b1) begin miscomp++; $display("FAIL single_latency: got %b expected 1", mem_req_o); end
    if (mem_req_o) begin
      vec++;
      if (sb.size() == 0) begin miscomp++; $display("FAIL single_issue: got request %h expected none", mem_addr_o); end
      else begin
        e = sb.pop_front(); got = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
        if (got !== e) begin miscomp++; $display("FAIL single_issue: got %h expected %h", got, e); end
      end
    end
    step();
    mem_gnt_i = 1'b0; mem_ack_i = 1'b1; mem_ack_tid_i = 2'd0;
    @(negedge clk);
    vec++; if (empty_o !== 1'b0) begin miscomp++; $display("FAIL single_pending: got %b expected 0", empty_o); end
    step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    vec++; if (empty_o !== 1'b1) begin miscomp++; $display("FAIL single_empty: got %b expected 1", empty_o); end
    vec++; if (err_o !== 1'b0) begin miscomp++; $display("FAIL single_err: got %b expected 0", err_o); end
    step();
  endtask

  task automatic test_coalesce();
    mem_gnt_i = 1'b0; st_valid_i = 1'b1;
    st_addr_i = 32'h100; st_data_i = 32'h0000_0011; st_be_i = 4'h1;
    @(negedge clk);
    vec++; if (st_ready_o !== 1'b1) begin miscomp++; $display("FAIL coal_ready0: got %b expected 1", st_ready_o); end
    step();
    st_addr_i = 32'h104; st_data_i = 32'h0000_00AA; st_be_i = 4'h1;
    @(negedge clk);
    vec++; if (st_ready_o !== 1'b1) begin miscomp++; $display("FAIL coal_ready1: got %b expected 1", st_ready_o); end
    step();
    st_addr_i = 32'h104; st_data_i = 32'h0000_2200; st_be_i = 4'h2;
    @(negedge clk);
    vec++; if (st_ready_o !== 1'b1) begin miscomp++; $display("FAIL coal_ready_merge: got %b expected 1", st_ready_o); end
    step();
    st_addr_i = 32'h108; st_data_i = 32'hFFFF_FFFF; st_be_i = 4'hF; ld_addr_i = 32'h104;
    @(negedge clk);
    vec++; if (st_ready_o !== 1'b0) begin miscomp++; $display("FAIL coal_count2: got ready %b expected 0", st_ready_o); end
    vec++; if (ld_hit_o !== 1'b1) begin miscomp++; $display("FAIL coal_ldhit: got %b expected 1", ld_hit_o); end
    step();
    st_valid_i = 1'b0;
    sb.push_back('{addr: 32'h100, data: 32'h0000_0011, be: 4'h1, tid: 2'd1});
    sb.push_back('{addr: 32'h104, data: 32'h0000_22AA, be: 4'h3, tid: 2'd2});
    mem_gnt_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req_o) begin
        vec++;
        if (sb.size() == 0) begin miscomp++; $display("FAIL coal_issue: got request %h expected none", mem_addr_o); end
        else begin
          e = sb.pop_front(); got = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
          if (got !== e) begin miscomp++; $display("FAIL coal_issue: got %h expected %h", got, e); end
        end
      end
      step();
    end
    mem_gnt_i = 1'b0;
    vec++; if (sb.size() != 0) begin miscomp++; $display("FAIL coal_drain: got %0d left expected 0", sb.size()); sb.delete(); end
    mem_ack_i = 1'b1; mem_ack_tid_i = 2'd1; step();
    mem_ack_tid_i = 2'd2; step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    vec++; if ({empty_o, err_o} !== 2'b10) begin miscomp++; $display("FAIL coal_done: got empty/err %b expected 10", {empty_o, err_o}); end
    step();
  endtask

  task automatic test_max_out();
    int   k = 0;
    int   grants = 0;
    logic acc;
    rst_i = 1'b1; sb.delete(); step(); rst_i = 1'b0;
    mem_gnt_i = 1'b1; st_be_i = 4'hF;
    for (int c = 0; c < 30; c++) begin
      st_valid_i = (k < 8);
      st_addr_i  = 32'h0000_1000 + 32'(k) * 4;
      st_data_i  = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      acc = st_valid_i && st_ready_o;
      if (mem_req_o) begin
        grants++; vec++;
        if (sb.size() == 0) begin miscomp++; $display("FAIL maxout_issue: got request %h expected none", mem_addr_o); end
        else begin
          e = sb.pop_front(); got = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
          if (got !== e) begin miscomp++; $display("FAIL maxout_issue: got %h expected %h", got, e); end
        end
      end
      if (acc) sb.push_back('{addr: st_addr_i, data: st_data_i, be: 4'hF, tid: 2'(k)});
      step();
      if (acc) k++;
    end
    st_valid_i = 1'b0;
    @(negedge clk);
    vec++; if (grants != 7) begin miscomp++; $display("FAIL maxout_grants: got %0d expected 7", grants); end
    vec++; if (mem_req_o !== 1'b0) begin miscomp++; $display("FAIL maxout_req_drop: got %b expected 0", mem_req_o); end
    vec++; if (k != 8) begin miscomp++; $display("FAIL maxout_accepted: got %0d expected 8", k); end
    step();
    mem_ack_i = 1'b1; mem_ack_tid_i = 2'd0; step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    vec++; if (mem_req_o !== 1'b1) begin miscomp++; $display("FAIL maxout_resume: got %b expected 1", mem_req_o); end
    if (mem_req_o) begin
      vec++;
      if (sb.size() == 0) begin miscomp++; $display("FAIL maxout_eighth: got request %h expected none", mem_addr_o); end
      else begin
        e = sb.pop_front(); got = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
        if (got !== e) begin miscomp++; $display("FAIL maxout_eighth: got %h expected %h", got, e); end
      end
    end
    step();
    mem_gnt_i = 1'b0;
  endtask

  task automatic test_gnt_ack();
    int   n = 0;
    int   grants = 0;
    logic acc;
    rst_i = 1'b1; sb.delete(); step(); rst_i = 1'b0;
    mem_gnt_i = 1'b1; st_be_i = 4'hF;
    for (int c = 0; c < 5; c++) begin
      st_valid_i = (c < 4);
      st_addr_i  = 32'h2000 + 32'(c) * 4;
      st_data_i  = 32'h5500_0000 + 32'(c);
      mem_ack_i  = (c == 4); mem_ack_tid_i = 2'd0;
      @(negedge clk);
      acc = st_valid_i && st_ready_o;
      if (mem_req_o) begin
        grants++; vec++;
        if (sb.size() == 0) begin miscomp++; $display("FAIL gntack_issue: got request %h expected none", mem_addr_o); end
        else begin
          e = sb.pop_front(); got = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
          if (got !== e) begin miscomp++; $display("FAIL gntack_issue: got %h expected %h", got, e); end
        end
      end
      if (acc) begin sb.push_back('{addr: st_addr_i, data: st_data_i, be: 4'hF, tid: 2'(n)}); n++; end
      step();
    end
    st_valid_i = 1'b0; mem_ack_i = 1'b0; mem_gnt_i = 1'b0;
    @(negedge clk);
    vec++; if (grants != 4) begin miscomp++; $display("FAIL gntack_grants: got %0d expected 4", grants); end
    step();
    for (int t = 1; t < 4; t++) begin
      mem_ack_i = 1'b1; mem_ack_tid_i = 2'(t); step();
    end
    mem_ack_i = 1'b0;
    @(negedge clk);
    vec++; if ({empty_o, err_o} !== 2'b10) begin miscomp++; $display("FAIL gntack_out3: got empty/err %b expected 10", {empty_o, err_o}); end
    step();
    // Two more writes (tids 0,1), then a wrong-TID acknowledge.
    mem_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      st_valid_i = (c < 2);
      st_addr_i  = 32'h2100 + 32'(c) * 4;
      st_data_i  = 32'h6600_0000 + 32'(c);
      @(negedge clk);
      acc = st_valid_i && st_ready_o;
      if (mem_req_o) begin
        vec++;
        if (sb.size() == 0) begin miscomp++; $display("FAIL gntack_issue2: got request %h expected none", mem_addr_o); end
        else begin
          e = sb.pop_front(); got = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
          if (got !== e) begin miscomp++; $display("FAIL gntack_issue2: got %h expected %h", got, e); end
        end
      end
      if (acc) begin sb.push_back('{addr: st_addr_i, data: st_data_i, be: 4'hF, tid: 2'(n)}); n++; end
      step();
    end
    st_valid_i = 1'b0; mem_gnt_i = 1'b0;
    mem_ack_i = 1'b1; mem_ack_tid_i = 2'd0; step();
    mem_ack_tid_i = 2'd2; step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    vec++; if (err_o !== 1'b1) begin miscomp++; $display("FAIL gntack_tid_err: got %b expected 1", err_o); end
    step(); step(); step();
    @(negedge clk);
    vec++; if (err_o !== 1'b1) begin miscomp++; $display("FAIL gntack_err_sticky: got %b expected 1", err_o); end
    step();
    rst_i = 1'b1; step(); rst_i = 1'b0; sb.delete();
    @(negedge clk);
    vec++; if (err_o !== 1'b0) begin miscomp++; $display("FAIL gntack_err_clear: got %b expected 0", err_o); end
    step();
    mem_ack_i = 1'b1; mem_ack_tid_i = 2'd0; step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    vec++; if ({err_o, empty_o} !== 2'b11) begin miscomp++; $display("FAIL idle_ack_err: got err/empty %b expected 11", {err_o, empty_o}); end
    step();
  endtask

  task automatic test_full();
    rst_i = 1'b1; sb.delete(); step(); rst_i = 1'b0;
    mem_gnt_i = 1'b0; st_valid_i = 1'b1; st_be_i = 4'hF;
    st_addr_i = 32'h200; st_data_i = 32'h0A0A_0A0A; step();
    st_addr_i = 32'h204; st_data_i = 32'h0B0B_0B0B; step();
    st_addr_i = 32'h208; st_data_i = 32'hEEEE_EEEE;
    @(negedge clk);
    vec++; if (st_ready_o !== 1'b0) begin miscomp++; $display("FAIL full_new_word: got ready %b expected 0", st_ready_o); end
    step();
    st_addr_i = 32'h204; st_data_i = 32'h00CC_0000; st_be_i = 4'h4;
    @(negedge clk);
    vec++; if (st_ready_o !== 1'b1) begin miscomp++; $display("FAIL full_merge: got ready %b expected 1", st_ready_o); end
    step();
    st_valid_i = 1'b0; ld_addr_i = 32'h200;
    @(negedge clk);
    vec++; if (ld_hit_o !== 1'b1) begin miscomp++; $display("FAIL full_ldhit_head: got %b expected 1", ld_hit_o); end
    step();
    ld_addr_i = 32'h206;
    @(negedge clk);
    vec++; if (ld_hit_o !== 1'b1) begin miscomp++; $display("FAIL full_ldhit_tail: got %b expected 1", ld_hit_o); end
    step();
    ld_addr_i = 32'h208;
    @(negedge clk);
    vec++; if (ld_hit_o !== 1'b0) begin miscomp++; $display("FAIL full_ldmiss: got %b expected 0", ld_hit_o); end
    step();
    sb.push_back('{addr: 32'h200, data: 32'h0A0A_0A0A, be: 4'hF, tid: 2'd0});
    sb.push_back('{addr: 32'h204, data: 32'h0BCC_0B0B, be: 4'hF, tid: 2'd1});
    mem_gnt_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req_o) begin
        vec++;
        if (sb.size() == 0) begin miscomp++; $display("FAIL full_issue: got request %h expected none", mem_addr_o); end
        else begin
          e = sb.pop_front(); got = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
          if (got !== e) begin miscomp++; $display("FAIL full_issue: got %h expected %h", got, e); end
        end
      end
      step();
    end
    mem_gnt_i = 1'b0;
    vec++; if (sb.size() != 0) begin miscomp++; $display("FAIL full_drain: got %0d left expected 0", sb.size()); sb.delete(); end
    mem_ack_i = 1'b1; mem_ack_tid_i = 2'd0; step();
    mem_ack_tid_i = 2'd1; step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    vec++; if ({empty_o, err_o} !== 2'b10) begin miscomp++; $display("FAIL full_done: got empty/err %b expected 10", {empty_o, err_o}); end
    step();
  endtask

  task automatic test_reset_inflight();
    rst_i = 1'b1; sb.delete(); step(); rst_i = 1'b0;
    mem_gnt_i = 1'b1; st_be_i = 4'hF;
    for (int c = 0; c < 4; c++) begin
      st_valid_i = (c < 3);
      st_addr_i  = 32'h300 + 32'(c) * 4;
      st_data_i  = 32'h7700_0000 + 32'(c);
      @(negedge clk);
      if (st_valid_i && st_ready_o) sb.push_back('{addr: st_addr_i, data: st_data_i, be: 4'hF, tid: 2'(c)});
      step();
    end
    mem_gnt_i = 1'b0; st_valid_i = 1'b1;
    st_addr_i = 32'h400; step();
    st_addr_i = 32'h404; step();
    st_valid_i = 1'b0;
    @(negedge clk);
    vec++; if (mem_req_o !== 1'b1) begin miscomp++; $display("FAIL rstfl_pending: got %b expected 1", mem_req_o); end
    step();
    rst_i = 1'b1; step(); rst_i = 1'b0; sb.delete();
    ld_addr_i = 32'h400;
    @(negedge clk);
    vec++; if (mem_req_o !== 1'b0) begin miscomp++; $display("FAIL rstfl_req: got %b expected 0", mem_req_o); end
    vec++; if (empty_o !== 1'b1) begin miscomp++; $display("FAIL rstfl_empty: got %b expected 1", empty_o); end
    vec++; if (st_ready_o !== 1'b1) begin miscomp++; $display("FAIL rstfl_ready: got %b expected 1", st_ready_o); end
    vec++; if (ld_hit_o !== 1'b0) begin miscomp++; $display("FAIL rstfl_ldhit: got %b expected 0", ld_hit_o); end
    step();
    st_valid_i = 1'b1; st_addr_i = 32'h500; st_data_i = 32'h1234_5678; st_be_i = 4'hF;
    sb.push_back('{addr: 32'h500, data: 32'h1234_5678, be: 4'hF, tid: 2'd0});
    step();
    st_valid_i = 1'b0; mem_gnt_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_req_o) begin
        vec++;
        if (sb.size() == 0) begin miscomp++; $display("FAIL rstfl_issue: got request %h expected none", mem_addr_o); end
        else begin
          e = sb.pop_front(); got = {mem_addr_o, mem_data_o, mem_be_o, mem_tid_o};
          if (got !== e) begin miscomp++; $display("FAIL rstfl_issue: got %h expected %h", got, e); end
        end
      end
      step();
    end
    mem_gnt_i = 1'b0;
    vec++; if (sb.size() != 0) begin miscomp++; $display("FAIL rstfl_drain: got %0d left expected 0", sb.size()); sb.delete(); end
    mem_ack_i = 1'b1; mem_ack_tid_i = 2'd0; step();
    mem_ack_i = 1'b0;
    @(negedge clk);
    vec++; if ({empty_o, err_o} !== 2'b10) begin miscomp++; $display("FAIL rstfl_done: got empty/err %b expected 10", {empty_o, err_o}); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_coalesce();
    test_max_out();
    test_gnt_ack();
    test_full();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end

endmodule
